// File: rtl/pc_pkg.sv
// Shared PC-source encodings and default vector addresses for the PC sequencer.
package pc_pkg;

    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_BR  = 3'b001;
    localparam logic [2:0] PCSRC_J   = 3'b010;
    localparam logic [2:0] PCSRC_JR  = 3'b011;
    localparam logic [2:0] PCSRC_IRQ = 3'b100;
    localparam logic [2:0] PCSRC_EXC = 3'b101;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] DEF_IRQ_VECTOR   = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0008;

    localparam int unsigned DEF_IRQ_SYNC_STAGES = 2;

endpackage

// File: rtl/irq_sync_edge.sv
// Synchroniser for an asynchronous level input followed by a rising-edge detector.
module irq_sync_edge
    import pc_pkg::*;
#(
    parameter int unsigned STAGES = DEF_IRQ_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    // chain_q[STAGES-1] is the synchronised level; chain_q[STAGES] is its previous value.
    logic [STAGES:0] chain_q, chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-1:0], async_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign rise_pulse = chain_q[STAGES-1] & ~chain_q[STAGES];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: PC register, next-PC selection, interrupt pending latch and
// misaligned-JR exception pulse.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR    = DEF_RESET_VECTOR,
    parameter logic [31:0] IRQ_VECTOR      = DEF_IRQ_VECTOR,
    parameter logic [31:0] EXC_VECTOR      = DEF_EXC_VECTOR,
    parameter int unsigned IRQ_SYNC_STAGES = DEF_IRQ_SYNC_STAGES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  pc_src,
    input  logic        alu_out0,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  logic [31:0] rs_data,
    input  logic        irq_raw,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] link_addr,
    output logic        irq_req,
    output logic        kernel,
    output logic        exc_misalign
);

    logic [31:0] pc_q, pc_d;
    logic        pending_q, pending_d;
    logic        misalign_q, misalign_d;
    logic        irq_rise;
    logic [31:0] br_target;
    logic [31:0] target;
    logic        keep_k;

    irq_sync_edge #(
        .STAGES (IRQ_SYNC_STAGES)
    ) u_irq_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .async_in   (irq_raw),
        .rise_pulse (irq_rise)
    );

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        target     = pc_q;
        keep_k     = 1'b1;
        misalign_d = 1'b0;
        unique case (pc_src)
            PCSRC_SEQ: target = pc_plus4;
            PCSRC_BR:  target = alu_out0 ? br_target : pc_plus4;
            PCSRC_J:   target = {pc_plus4[31:28], jtarget, 2'b00};
            PCSRC_JR: begin
                keep_k = 1'b0;
                if (rs_data[1:0] == 2'b00) begin
                    // A user-mode JR can never enter kernel space.
                    target = {pc_q[31] & rs_data[31], rs_data[30:0]};
                end else begin
                    target     = EXC_VECTOR;
                    misalign_d = 1'b1;
                end
            end
            PCSRC_IRQ: begin
                keep_k = 1'b0;
                target = IRQ_VECTOR;
            end
            default: begin
                keep_k = 1'b0;
                target = EXC_VECTOR;
            end
        endcase

        // Sequential/branch/J paths preserve the kernel bit; only JR and vectors change it.
        pc_d = {keep_k ? pc_q[31] : target[31], target[30:0]};

        if (stall) begin
            pc_d       = pc_q;
            misalign_d = 1'b0;
        end

        // A fresh edge in the acknowledge cycle takes priority over the clear.
        pending_d = irq_rise | (pending_q & ~((pc_src == PCSRC_IRQ) & ~stall));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            pending_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc           = pc_q;
    assign kernel       = pc_q[31];
    assign irq_req      = pending_q & ~pc_q[31];
    assign exc_misalign = misalign_q;
    assign link_addr    = (pc_src == PCSRC_IRQ) ? pc_q : pc_plus4;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomised bench for pc_sequencer, checked against an arithmetic reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h8000_0000;
    localparam logic [31:0] IV = 32'h8000_0004;
    localparam logic [31:0] EV = 32'h8000_0008;
    localparam int          S  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  pc_src = 3'b000;
    logic        alu_out0 = 1'b0;
    logic [15:0] imm16 = '0;
    logic [25:0] jtarget = '0;
    logic [31:0] rs_data = '0;
    logic        irq_raw = 1'b0;
    logic [31:0] pc, pc_plus4, link_addr;
    logic        irq_req, kernel, exc_misalign;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_pc = '0;
    bit          m_pending = 0;
    bit          m_mis = 0;
    bit          m_valid = 0;
    bit          hist[$];
    bit          irq_lvl = 0;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_src       (pc_src),
        .alu_out0     (alu_out0),
        .imm16        (imm16),
        .jtarget      (jtarget),
        .rs_data      (rs_data),
        .irq_raw      (irq_raw),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .link_addr    (link_addr),
        .irq_req      (irq_req),
        .kernel       (kernel),
        .exc_misalign (exc_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the rules of the block's behaviour.
    task automatic model_edge(input bit rst, input bit st, input logic [2:0] src, input bit alu,
                              input logic [15:0] imm, input logic [25:0] jt,
                              input logic [31:0] rs, input bit irq);
        logic [31:0] p4, np;
        int          off;
        bit          rise;
        if (rst) begin
            m_pc      = RV;
            m_pending = 0;
            m_mis     = 0;
            m_valid   = 1;
            hist.delete();
            for (int i = 0; i <= S; i++) hist.push_back(1'b0);
            return;
        end
        // An irq_raw rise sampled S edges ago becomes visible now.
        rise = hist[hist.size() - S] && !hist[hist.size() - S - 1];
        np   = m_pc;
        m_mis = 0;
        if (!st) begin
            p4 = m_pc + 32'd4;
            case (src)
                3'd0: np = p4;
                3'd1: begin
                    off = $signed(imm);
                    np  = alu ? p4 + 32'(off * 4) : p4;
                end
                3'd2: np = (p4 & 32'hF000_0000) | (32'(jt) << 2);
                3'd3: begin
                    if (rs % 4 == 0) np = m_pc[31] ? rs : (rs & 32'h7FFF_FFFF);
                    else begin
                        np    = EV;
                        m_mis = 1;
                    end
                end
                3'd4:    np = IV;
                default: np = EV;
            endcase
            if (src <= 3'd2) np[31] = m_pc[31];
            m_pc = np;
        end
        if (rise) m_pending = 1;
        else if (!st && src == 3'd4) m_pending = 0;
        hist.push_back(irq);
        void'(hist.pop_front());
    endtask

    task automatic step(input bit rst, input bit st, input logic [2:0] src, input bit alu,
                        input logic [15:0] imm, input logic [25:0] jt, input logic [31:0] rs);
        reset    = rst;
        stall    = st;
        pc_src   = src;
        alu_out0 = alu;
        imm16    = imm;
        jtarget  = jt;
        rs_data  = rs;
        irq_raw  = irq_lvl;
        #1;
        if (m_valid) begin
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("link_addr", link_addr, (src == 3'd4) ? m_pc : m_pc + 32'd4);
            chk1("irq_req", irq_req, m_pending && !m_pc[31]);
            chk1("kernel", kernel, m_pc[31]);
        end
        @(posedge clk);
        model_edge(rst, st, src, alu, imm, jt, rs, irq_lvl);
        #1;
        chk("pc", pc, m_pc);
        chk1("exc_misalign", exc_misalign, m_mis);
    endtask

    task automatic seq();
        step(0, 0, 3'd0, 0, '0, '0, '0);
    endtask

    task automatic jr(input logic [31:0] rs);
        step(0, 0, 3'd3, 0, '0, '0, rs);
    endtask

    initial begin
        bit          r_rst, r_st, r_alu;
        logic [2:0]  r_src;
        logic [31:0] r_rs;

        @(posedge clk);
        #1;
        repeat (3) step(1, 0, 3'd0, 0, '0, '0, '0);
        chk("reset_pc", pc, 32'h8000_0000);
        chk("reset_pc_plus4", pc_plus4, 32'h8000_0004);
        chk1("reset_kernel", kernel, 1'b1);
        chk1("reset_irq_req", irq_req, 1'b0);
        repeat (4) seq();
        chk("seq_x4", pc, 32'h8000_0010);

        // Branch taken/not taken with negative offset
        jr(32'h0040_0010);
        step(0, 0, 3'd1, 1, 16'hFFFC, '0, '0);
        chk("br_taken", pc, 32'h0040_0004);
        jr(32'h0040_0010);
        step(0, 0, 3'd1, 0, 16'hFFFC, '0, '0);
        chk("br_not_taken", pc, 32'h0040_0014);

        // JR kernel-bit rules and misalignment
        step(1, 0, 3'd0, 0, '0, '0, '0);
        jr(32'h8000_1000);
        chk("jr_kernel", pc, 32'h8000_1000);
        jr(32'h0040_0000);
        chk1("jr_to_user", kernel, 1'b0);
        jr(32'h8000_0100);
        chk("jr_user_no_kernel", pc, 32'h0000_0100);
        jr(32'h0040_0002);
        chk("jr_misalign_pc", pc, 32'h8000_0008);
        chk1("jr_misalign_pulse", exc_misalign, 1'b1);
        seq();
        chk1("misalign_one_cycle", exc_misalign, 1'b0);

        // IRQ latency and acknowledge
        jr(32'h0040_0014);
        irq_lvl = 1;
        seq();
        seq();
        chk1("irq_not_yet", irq_req, 1'b0);
        seq();
        chk1("irq_latency", irq_req, 1'b1);
        chk("irq_pc", pc, 32'h0040_0020);
        step(0, 0, 3'd4, 0, '0, '0, '0);
        chk("irq_vector", pc, 32'h8000_0004);
        chk1("irq_ack", irq_req, 1'b0);

        // Edge while in kernel mode stays masked until return to user
        irq_lvl = 0;
        seq();
        seq();
        irq_lvl = 1;
        repeat (4) seq();
        chk1("irq_masked_kernel", irq_req, 1'b0);
        jr(32'h0040_0000);
        chk1("irq_on_user_return", irq_req, 1'b1);
        repeat (5) step(0, 1, 3'd4, 0, '0, '0, '0);
        chk("stall_pc_hold", pc, 32'h0040_0000);
        chk1("stall_pending_kept", irq_req, 1'b1);

        // Reset while pending clears everything
        irq_lvl = 0;
        step(1, 0, 3'd2, 0, '0, 26'h3FF_FFFF, '0);
        chk("mid_reset_pc", pc, 32'h8000_0000);
        chk1("mid_reset_irq_req", irq_req, 1'b0);
        jr(32'h0040_0000);
        chk1("pending_cleared", irq_req, 1'b0);

        // Wrap-around of pc_plus4
        jr(32'h7FFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h8000_0000);

        // Randomised phase
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) irq_lvl = !irq_lvl;
            r_rst = ($urandom_range(0, 99) < 2);
            r_st  = ($urandom_range(0, 4) == 0);
            r_alu = 1'($urandom_range(0, 1));
            r_src = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7))
                                                 : 3'($urandom_range(0, 3));
            r_rs  = $urandom;
            if ($urandom_range(0, 3) != 0) r_rs[1:0] = 2'b00;
            step(r_rst, r_st, r_src, r_alu, 16'($urandom), 26'($urandom), r_rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
